// File: rtl/cpu_pkg.sv
// Shared MEM-stage types: FSM states, writeback source encodings, register index width.
package cpu_pkg;

    localparam int REG_NO_W = 5;

    localparam logic [1:0] DTR_ALU = 2'b00;
    localparam logic [1:0] DTR_MEM = 2'b01;
    localparam logic [1:0] DTR_EXT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus: registered request side from the controller, gnt/rvalid/rdata back from memory.
interface mem_access_ctrl_if;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );

endinterface

// File: rtl/mem_access_ctrl_wb.sv
// MEM/WB pipeline register: loads on pipe advance, otherwise holds and kills RegWrite when bubbling.
import cpu_pkg::*;

module mem_wb_reg (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_en,
    input  logic                bubble,
    input  logic [31:0]         read_data,
    input  logic [31:0]         alu_res,
    input  logic [31:0]         ext,
    input  logic [REG_NO_W-1:0] reg_write_no,
    input  logic                RegWrite,
    input  logic [1:0]          DatatoReg,
    output logic [31:0]         wb_read_data,
    output logic [31:0]         wb_alu_res,
    output logic [31:0]         wb_ext,
    output logic [REG_NO_W-1:0] wb_reg_write_no,
    output logic                wb_RegWrite,
    output logic [1:0]          wb_DatatoReg
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_read_data    <= '0;
            wb_alu_res      <= '0;
            wb_ext          <= '0;
            wb_reg_write_no <= '0;
            wb_RegWrite     <= 1'b0;
            wb_DatatoReg    <= '0;
        end else if (load_en) begin
            wb_read_data    <= read_data;
            wb_alu_res      <= alu_res;
            wb_ext          <= ext;
            wb_reg_write_no <= reg_write_no;
            wb_RegWrite     <= RegWrite;
            wb_DatatoReg    <= DatatoReg;
        end else if (bubble) begin
            wb_RegWrite     <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM stage: runs loads/stores over the req/gnt/rvalid bus and stalls the pipe until done.
// Define MEM_TIMEOUT_EN to abort stuck transactions after TIMEOUT_CYC cycles and flag bus_err.
import cpu_pkg::*;

module mem_access_ctrl #(
    parameter int          TIMEOUT_CYC = 16,
    parameter logic [31:0] RDATA_ERR   = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         ALURes,
    input  logic [31:0]         grf_out_B,
    input  logic [31:0]         ext,
    input  logic [REG_NO_W-1:0] reg_write_no,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic                RegWrite,
    input  logic [1:0]          DatatoReg,
    output logic                pipe_en,
    mem_access_ctrl_if.master   bus,
    output logic [31:0]         wb_read_data,
    output logic [31:0]         wb_alu_res,
    output logic [31:0]         wb_ext,
    output logic [REG_NO_W-1:0] wb_reg_write_no,
    output logic                wb_RegWrite,
    output logic [1:0]          wb_DatatoReg,
    output logic                bus_err
);

    mem_state_t  state_q, state_d;
    logic        mem_op;
    logic        req_d, we_d;
    logic [31:0] addr_d, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        cnt_clr, err_set, timeout;

    assign mem_op = MemRead | MemWrite;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            bus.dm_req   <= 1'b0;
            bus.dm_we    <= 1'b0;
            bus.dm_addr  <= '0;
            bus.dm_wdata <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            bus.dm_req   <= req_d;
            bus.dm_we    <= we_d;
            bus.dm_addr  <= addr_d;
            bus.dm_wdata <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // rdata_q is cleared at request time so a store's DONE writes 0 to wb_read_data.
    always_comb begin
        state_d = state_q;
        pipe_en = 1'b0;
        req_d   = bus.dm_req;
        we_d    = bus.dm_we;
        addr_d  = bus.dm_addr;
        wdata_d = bus.dm_wdata;
        rdata_d = rdata_q;
        cnt_clr = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = MemWrite;
                    addr_d  = {ALURes[31:2], 2'b00};
                    wdata_d = grf_out_B;
                    rdata_d = '0;
                    cnt_clr = 1'b1;
                end else begin
                    pipe_en = 1'b1;
                end
            end
            REQ: begin
                if (bus.dm_gnt) begin
                    req_d   = 1'b0;
                    state_d = bus.dm_we ? DONE : RESP;
                end else if (timeout) begin
                    req_d   = 1'b0;
                    err_set = 1'b1;
                    state_d = DONE;
                    if (!bus.dm_we) rdata_d = RDATA_ERR;
                end
            end
            RESP: begin
                if (bus.dm_rvalid) begin
                    rdata_d = bus.dm_rdata;
                    state_d = DONE;
                end else if (timeout) begin
                    err_set = 1'b1;
                    rdata_d = RDATA_ERR;
                    state_d = DONE;
                end
            end
            DONE: begin
                pipe_en = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (cnt_clr)
                cnt_q <= '0;
            else if (state_q == REQ || state_q == RESP)
                cnt_q <= cnt_q + 8'd1;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign timeout = (state_q == REQ || state_q == RESP) && (cnt_q == 8'(TIMEOUT_CYC - 1));
    assign bus_err = err_q;
`else
    logic unused_cfg;
    assign timeout    = 1'b0;
    assign bus_err    = 1'b0;
    assign unused_cfg = ^{32'(TIMEOUT_CYC), cnt_clr, err_set};
`endif

    mem_wb_reg u_mem_wb (
        .clk             (clk),
        .rst             (rst),
        .load_en         (pipe_en),
        .bubble          (~pipe_en),
        .read_data       ((state_q == DONE) ? rdata_q : 32'h0),
        .alu_res         (ALURes),
        .ext             (ext),
        .reg_write_no    (reg_write_no),
        .RegWrite        (RegWrite),
        .DatatoReg       (DatatoReg),
        .wb_read_data    (wb_read_data),
        .wb_alu_res      (wb_alu_res),
        .wb_ext          (wb_ext),
        .wb_reg_write_no (wb_reg_write_no),
        .wb_RegWrite     (wb_RegWrite),
        .wb_DatatoReg    (wb_DatatoReg)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: vector table with bus responder, MEM/WB scoreboard, reset/timeout sequences.
import cpu_pkg::*;

module tb_mem_access_ctrl;

    localparam int          TOC  = 4;
    localparam logic [31:0] ERRW = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALURes, grf_out_B, ext;
    logic [4:0]  reg_write_no;
    logic        MemRead, MemWrite, RegWrite;
    logic [1:0]  DatatoReg;
    logic        pipe_en;
    logic [31:0] wb_read_data, wb_alu_res, wb_ext;
    logic [4:0]  wb_reg_write_no;
    logic        wb_RegWrite;
    logic [1:0]  wb_DatatoReg;
    logic        bus_err;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT_CYC(TOC), .RDATA_ERR(ERRW)) dut (
        .clk(clk), .rst(rst), .ALURes(ALURes), .grf_out_B(grf_out_B), .ext(ext),
        .reg_write_no(reg_write_no), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .DatatoReg(DatatoReg), .pipe_en(pipe_en), .bus(bus),
        .wb_read_data(wb_read_data), .wb_alu_res(wb_alu_res), .wb_ext(wb_ext),
        .wb_reg_write_no(wb_reg_write_no), .wb_RegWrite(wb_RegWrite),
        .wb_DatatoReg(wb_DatatoReg), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, b, ext;
        logic [4:0]  rn;
        logic        mr, mw, rw;
        logic [1:0]  dtr;
        int          gnt_dly, rv_dly;
        logic [31:0] rdata;
        int          exp_stall;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [31:0] alu, ext, rd;
        logic [4:0]  rn;
        logic        rw;
        logic [1:0]  dtr;
    } wb_t;

    wb_t  sb[$];
    vec_t vecs[9];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one EX/MEM instruction, play memory with the vector's gnt/rvalid delays, check stall and MEM/WB.
    task automatic run_op(input vec_t v);
        int  stall = 0, req_cyc = 0, resp_cyc = 0;
        bit  granted = 0, done = 0;
        wb_t e, g;
        ALURes = v.alu; grf_out_B = v.b; ext = v.ext; reg_write_no = v.rn;
        MemRead = v.mr; MemWrite = v.mw; RegWrite = v.rw; DatatoReg = v.dtr;
        e.alu = v.alu; e.ext = v.ext; e.rd = v.exp_rd; e.rn = v.rn; e.rw = v.rw; e.dtr = v.dtr;
        sb.push_back(e);
        bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (pipe_en) begin
                done = 1;
            end else begin
                if (stall > 0) chk("bubble_regwrite", 32'(wb_RegWrite), 32'd0);
                if (stall == 0) chk("req_low_in_idle", 32'(bus.dm_req), 32'd0);
                if (stall == 1) begin
                    chk("req_rise", 32'(bus.dm_req), 32'd1);
                    chk("dm_addr", bus.dm_addr, {v.alu[31:2], 2'b00});
                    chk("dm_we", 32'(bus.dm_we), 32'(v.mw));
                    if (v.mw) chk("dm_wdata", bus.dm_wdata, v.b);
                end
                bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0;
                if (bus.dm_req) begin
                    if (req_cyc == v.gnt_dly) begin bus.dm_gnt = 1'b1; granted = 1; end
                    req_cyc++;
                end else if (granted && !v.mw) begin
                    if (resp_cyc == v.rv_dly) begin bus.dm_rvalid = 1'b1; bus.dm_rdata = v.rdata; end
                    resp_cyc++;
                end
                stall++;
                @(negedge clk);
            end
        end
        chk("completed_in_bound", 32'(done), 32'd1);
        chk("stall_cycles", 32'(stall), 32'(v.exp_stall));
        if (v.mr || v.mw) chk("req_low_in_done", 32'(bus.dm_req), 32'd0);
        bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0;
        @(posedge clk); #1;
        g.alu = wb_alu_res; g.ext = wb_ext; g.rd = wb_read_data;
        g.rn = wb_reg_write_no; g.rw = wb_RegWrite; g.dtr = wb_DatatoReg;
        e = sb.pop_front();
        chk("wb_alu_res", g.alu, e.alu);
        chk("wb_ext", g.ext, e.ext);
        chk("wb_read_data", g.rd, e.rd);
        chk("wb_reg_write_no", 32'(g.rn), 32'(e.rn));
        chk("wb_RegWrite", 32'(g.rw), 32'(e.rw));
        chk("wb_DatatoReg", 32'(g.dtr), 32'(e.dtr));
        @(negedge clk);
    endtask

    initial begin
        //          alu           b             ext           rn  mr mw rw dtr      gnt rv rdata         stall exp_rd
        vecs[0] = '{32'h10,       32'h0,        32'h0,        5,  0, 0, 1, DTR_ALU, 0,  0, 32'h0,        0, 32'h0};
        vecs[1] = '{32'hFFFF0000, 32'h1,        32'h1234,     31, 0, 0, 1, DTR_EXT, 0,  0, 32'h0,        0, 32'h0};
        vecs[2] = '{32'h0,        32'h0,        32'h0,        0,  0, 0, 0, DTR_ALU, 0,  0, 32'h0,        0, 32'h0};
        vecs[3] = '{32'h103,      32'hCAFE0001, 32'h3,        0,  0, 1, 0, DTR_ALU, 1,  0, 32'h0,        3, 32'h0};
        vecs[4] = '{32'h200,      32'h0,        32'h4,        7,  1, 0, 1, DTR_MEM, 0,  2, 32'h12345678, 5, 32'h12345678};
        vecs[5] = '{32'h2FF,      32'h0,        32'h5,        8,  1, 0, 1, DTR_MEM, 0,  0, 32'hA5A5A5A5, 3, 32'hA5A5A5A5};
        vecs[6] = '{32'h300,      32'h0,        32'h6,        9,  1, 0, 1, DTR_MEM, 2,  1, 32'h0BADF00D, 6, 32'h0BADF00D};
        vecs[7] = '{32'h42,       32'h55,       32'h7,        3,  1, 1, 0, DTR_ALU, 0,  0, 32'h77777777, 2, 32'h0};
        vecs[8] = '{32'h77,       32'h0,        32'h88,       12, 0, 0, 1, DTR_ALU, 0,  0, 32'h0,        0, 32'h0};

        rst = 1'b0;
        ALURes = '0; grf_out_B = '0; ext = '0; reg_write_no = '0;
        MemRead = 0; MemWrite = 0; RegWrite = 0; DatatoReg = '0;
        bus.dm_gnt = 0; bus.dm_rvalid = 0; bus.dm_rdata = '0;
        #2;
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_dm_req", 32'(bus.dm_req), 32'd0);
        chk("rst_dm_addr", bus.dm_addr, 32'd0);
        chk("rst_dm_wdata", bus.dm_wdata, 32'd0);
        chk("rst_wb_alu_res", wb_alu_res, 32'd0);
        chk("rst_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // vecs[5] and vecs[6] are back-to-back loads; run_op checks dm_req stays low through DONE and the next IDLE.
        for (int i = 0; i < 9; i++) run_op(vecs[i]);

        // Reset asserted while the load waits in RESP.
        ALURes = 32'h500; MemRead = 1; MemWrite = 0; RegWrite = 1; reg_write_no = 5'd9; DatatoReg = DTR_MEM;
        @(negedge clk);
        bus.dm_gnt = 1'b1;
        @(negedge clk);
        bus.dm_gnt = 1'b0;
        chk("in_resp_before_reset", 32'(dut.state_q), 32'(RESP));
        #1 rst = 1'b0;
        #1;
        chk("rstmid_dm_req", 32'(bus.dm_req), 32'd0);
        chk("rstmid_wb_alu_res", wb_alu_res, 32'd0);
        chk("rstmid_wb_ext", wb_ext, 32'd0);
        chk("rstmid_wb_read_data", wb_read_data, 32'd0);
        chk("rstmid_wb_reg_write_no", 32'(wb_reg_write_no), 32'd0);
        chk("rstmid_wb_DatatoReg", 32'(wb_DatatoReg), 32'd0);
        MemRead = 0; RegWrite = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("after_reset_state", 32'(dut.state_q), 32'(IDLE));
        chk("after_reset_pipe_en", 32'(pipe_en), 32'd1);

`ifdef MEM_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{32'h600, 32'h0, 32'h9, 4, 1, 0, 1, DTR_MEM, 1000, 0, 32'h0, 1 + TOC, ERRW};
            run_op(tv);
            chk("bus_err_sticky", 32'(bus_err), 32'd1);
        end
`else
        chk("bus_err_tied", 32'(bus_err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
